// File: rtl/hilo_sequencer_pkg.sv
// hilo_sequencer_pkg: op/mthilo encodings, FSM state type and op-class helper shared by the HI/LO sequencer slice
package hilo_sequencer_pkg;
  localparam logic [3:0] MUL_NONE  = 4'd0;
  localparam logic [3:0] MUL_MULT  = 4'd1;
  localparam logic [3:0] MUL_MULTU = 4'd2;
  localparam logic [3:0] MUL_DIV   = 4'd3;
  localparam logic [3:0] MUL_DIVU  = 4'd4;
  localparam logic [3:0] MUL_MADD  = 4'd5;
  localparam logic [3:0] MUL_MADDU = 4'd6;
  localparam logic [3:0] MUL_MSUB  = 4'd7;
  localparam logic [3:0] MUL_MSUBU = 4'd8;
  localparam logic [1:0] MTHILO_NONE = 2'b00;
  localparam logic [1:0] MTHILO_LO   = 2'b01;
  localparam logic [1:0] MTHILO_HI   = 2'b10;
  typedef enum logic {IDLE, RUN} hiloStateT;
  function automatic logic isDivOp(input logic [3:0] op);
    return op == MUL_DIV || op == MUL_DIVU;
  endfunction
endpackage

// File: rtl/hilo_sequencer_if.sv
// hilo_sequencer_if: EX-stage request bus and HI/LO status outputs
//   master (EX stage / bench): drives start, op, src_a, src_b, mthilo, flush; reads hi, lo, busy, done
//   slave (sequencer): the reverse
interface hilo_sequencer_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [1:0]  mthilo;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  modport master(output start, op, src_a, src_b, mthilo, flush, input hi, lo, busy, done);
  modport slave(input start, op, src_a, src_b, mthilo, flush, output hi, lo, busy, done);
endinterface

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: combinational 32-bit signed/unsigned divide with MIPS-style zero-divisor result
//   dividend, divisor : operands; isSigned : treat operands as two's complement
//   quotient, remainder : truncating quotient, remainder carries dividend sign
module hilo_div_unit (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        isSigned,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  logic        negA, negB;
  logic [31:0] magA, magB, safeB, uq, ur;
  // Divide magnitudes then restore signs; 0x80000000 / -1 falls out naturally as q=0x80000000, r=0.
  always_comb begin
    negA = isSigned & dividend[31];
    negB = isSigned & divisor[31];
    magA = negA ? -dividend : dividend;
    magB = negB ? -divisor : divisor;
    safeB = magB == 32'd0 ? 32'd1 : magB;
    uq = magA / safeB;
    ur = magA % safeB;
    quotient = divisor == 32'd0 ? '1 : (negA ^ negB) ? -uq : uq;
    remainder = divisor == 32'd0 ? dividend : negA ? -ur : ur;
  end
endmodule

// File: rtl/hilo_sequencer.sv
// hilo_sequencer: multi-cycle MULT/DIV sequencer committing a 64-bit result to HI/LO after a fixed latency
//   clk, reset : clock, synchronous active-high reset
//   bus        : hilo_sequencer_if.slave (start/op/src_a/src_b/mthilo/flush in; hi/lo/busy/done out)
//   HILO_MADD_EN : when defined, MADD/MADDU/MSUB/MSUBU accumulate into HI/LO; otherwise they are ignored
module hilo_sequencer #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic            clk,
  input logic            reset,
  hilo_sequencer_if.slave bus
);
  import hilo_sequencer_pkg::*;
  localparam int CW = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);
  hiloStateT     state, nextState;
  logic [CW-1:0] cnt;
  logic [31:0]   hiR, loR, shHi, shLo, quo, rem;
  logic [63:0]   sProd, uProd, result;
  logic          doneR, mulOp, maddOp, divOp, accept, commit;

  hilo_div_unit divUnit (
    .dividend (bus.src_a),
    .divisor  (bus.src_b),
    .isSigned (bus.op == MUL_DIV),
    .quotient (quo),
    .remainder(rem)
  );

  always_comb begin
    sProd = $signed({{32{bus.src_a[31]}}, bus.src_a}) * $signed({{32{bus.src_b[31]}}, bus.src_b});
    uProd = {32'd0, bus.src_a} * {32'd0, bus.src_b};
    mulOp = bus.op == MUL_MULT || bus.op == MUL_MULTU;
    divOp = isDivOp(bus.op);
`ifdef HILO_MADD_EN
    maddOp = bus.op inside {MUL_MADD, MUL_MADDU, MUL_MSUB, MUL_MSUBU};
    result = bus.op == MUL_MADD  ? {hiR, loR} + sProd :
             bus.op == MUL_MADDU ? {hiR, loR} + uProd :
             bus.op == MUL_MSUB  ? {hiR, loR} - sProd :
             bus.op == MUL_MSUBU ? {hiR, loR} - uProd :
             bus.op == MUL_MULT  ? sProd :
             bus.op == MUL_MULTU ? uProd : {rem, quo};
`else
    maddOp = 1'b0;
    result = bus.op == MUL_MULT ? sProd : bus.op == MUL_MULTU ? uProd : {rem, quo};
`endif
    // mthilo and flush both take priority over a start in the same cycle
    accept = state == IDLE && bus.start && (mulOp || maddOp || divOp) && bus.mthilo == MTHILO_NONE && !bus.flush;
    commit = state == RUN && !bus.flush && cnt == CW'(1);
    nextState = accept ? RUN : (state == RUN && (bus.flush || cnt == CW'(1))) ? IDLE : state;
  end

  always_ff @(posedge clk) state <= reset ? IDLE : nextState;

  always_ff @(posedge clk) begin
    if (reset) begin
      hiR <= '0;
      loR <= '0;
      shHi <= '0;
      shLo <= '0;
      cnt <= '0;
      doneR <= 1'b0;
    end else begin
      doneR <= commit;
      if (accept) begin
        {shHi, shLo} <= result;
        cnt <= divOp ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      end else if (state == RUN) cnt <= cnt - CW'(1);
      if (commit) {hiR, loR} <= {shHi, shLo};
      else if (state == IDLE && bus.mthilo == MTHILO_HI) hiR <= bus.src_a;
      else if (state == IDLE && bus.mthilo == MTHILO_LO) loR <= bus.src_a;
    end
  end

  assign bus.hi = hiR;
  assign bus.lo = loR;
  assign bus.busy = state == RUN;
  assign bus.done = doneR;
endmodule

// File: tb/tb_hilo_sequencer.sv
// tb_hilo_sequencer: scoreboard bench for hilo_sequencer with directed cases and randomized ops against an arithmetic reference
module tb_hilo_sequencer;
  import hilo_sequencer_pkg::*;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] modelHi = '0, modelLo = '0;
  logic [63:0] expQ[$];
  logic [3:0] ops[4] = '{MUL_MULT, MUL_MULTU, MUL_DIV, MUL_DIVU};

  hilo_sequencer_if bus();
  hilo_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] refResult(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint p;
    sa = a;
    sb = b;
    case (o)
      MUL_MULT: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      MUL_MULTU: return {32'd0, a} * {32'd0, b};
      MUL_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      MUL_DIVU: return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 15));
      default: return $urandom();
    endcase
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: got done=1 hi=%h lo=%h expected no commit", bus.hi, bus.lo);
      end else check("commit_hilo", {bus.hi, bus.lo}, expQ.pop_front());
    end
  end

  always @(posedge clk) begin
    if (!reset) assert (!(bus.start && bus.busy)) else begin
      failures++;
      $display("FAIL start_while_busy: got start=1 busy=1 expected start only when idle");
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called and returns at a negedge; measures how many cycles busy stays high after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int n,
                       input logic [1:0] midMt = 2'b00, input logic [31:0] midVal = 32'd0);
    int c;
    bus.start = 1'b1;
    bus.op = o;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.op = MUL_NONE;
    c = 0;
    @(negedge clk);
    while (bus.busy && c < 60) begin
      c++;
      if (c == 2 && midMt != 2'b00) begin
        bus.mthilo = midMt;
        bus.src_a = midVal;
      end else bus.mthilo = 2'b00;
      @(negedge clk);
    end
    bus.mthilo = 2'b00;
    check("busy_len", 64'(c), 64'(n));
  endtask

  task automatic runOp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                       input int n, input logic [1:0] midMt = 2'b00, input logic [31:0] midVal = 32'd0);
    expQ.push_back(exp);
    {modelHi, modelLo} = exp;
    issue(o, a, b, n, midMt, midVal);
  endtask

  task automatic mtWrite(input logic [1:0] m, input logic [31:0] v);
    bus.mthilo = m;
    bus.src_a = v;
    @(posedge clk);
    #1 bus.mthilo = 2'b00;
    @(negedge clk);
    if (m == MTHILO_HI) modelHi = v;
    if (m == MTHILO_LO) modelLo = v;
    check("mthilo_write", {bus.hi, bus.lo}, {modelHi, modelLo});
  endtask

  initial begin : main
    logic [3:0] o;
    logic [31:0] a, b;
    int w;
    bus.start = 1'b0;
    bus.op = MUL_NONE;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.mthilo = 2'b00;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    runOp(MUL_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, MUL_N);
    runOp(MUL_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_N);
    runOp(MUL_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_N);
    runOp(MUL_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, DIV_N);
    runOp(MUL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, DIV_N);
    // flush on the third busy cycle of a divide
    bus.start = 1'b1;
    bus.op = MUL_DIV;
    bus.src_a = 32'd20;
    bus.src_b = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_hilo", {bus.hi, bus.lo}, {modelHi, modelLo});
    idle(15);
    check("flush_no_commit", {bus.hi, bus.lo}, {modelHi, modelLo});
    // MTHI while idle, MTLO while busy
    mtWrite(MTHILO_HI, 32'h1234);
    runOp(MUL_MULT, 32'd7, 32'd9, {32'd0, 32'd63}, MUL_N, MTHILO_LO, 32'hDEAD_BEEF);
    idle(2);
    check("mtlo_busy_ignored", {bus.hi, bus.lo}, {modelHi, modelLo});
    // mthilo and start in the same cycle: write happens, op dropped
    bus.start = 1'b1;
    bus.op = MUL_MULT;
    bus.src_a = 32'h0000_ABCD;
    bus.src_b = 32'd2;
    bus.mthilo = MTHILO_LO;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.mthilo = 2'b00;
    @(negedge clk);
    modelLo = 32'h0000_ABCD;
    check("mthilo_beats_start_busy", {63'd0, bus.busy}, 64'd0);
    check("mthilo_beats_start_hilo", {bus.hi, bus.lo}, {modelHi, modelLo});
    // flush and start in the same cycle
    bus.start = 1'b1;
    bus.op = MUL_MULTU;
    bus.src_a = 32'd11;
    bus.src_b = 32'd13;
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", {63'd0, bus.busy}, 64'd0);
    idle(8);
    check("flush_start_hilo", {bus.hi, bus.lo}, {modelHi, modelLo});
    issue(4'hF, 32'd3, 32'd4, 0);
    issue(MUL_NONE, 32'd3, 32'd4, 0);
    check("bad_op_hilo", {bus.hi, bus.lo}, {modelHi, modelLo});
    // reset during the second busy cycle of a multiply
    bus.start = 1'b1;
    bus.op = MUL_MULT;
    bus.src_a = 32'd123;
    bus.src_b = 32'd456;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    modelHi = '0;
    modelLo = '0;
    check("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midreset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    idle(8);
    runOp(MUL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_N);
    // multiply-accumulate: active only with HILO_MADD_EN
    mtWrite(MTHILO_LO, 32'h10);
    mtWrite(MTHILO_HI, 32'h0);
`ifdef HILO_MADD_EN
    runOp(MUL_MADD, 32'd2, 32'd3, {32'd0, 32'h16}, MUL_N);
    runOp(MUL_MSUBU, 32'd1, 32'h17, 64'hFFFF_FFFF_FFFF_FFFF, MUL_N);
`else
    issue(MUL_MADD, 32'd2, 32'd3, 0);
    check("madd_disabled_hilo", {bus.hi, bus.lo}, {modelHi, modelLo});
    issue(MUL_MSUBU, 32'd1, 32'h17, 0);
    check("msubu_disabled_hilo", {bus.hi, bus.lo}, {modelHi, modelLo});
`endif
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) mtWrite($urandom_range(0, 1) == 1 ? MTHILO_HI : MTHILO_LO, $urandom());
      o = ops[$urandom_range(0, 3)];
      a = randOperand();
      b = randOperand();
      runOp(o, a, b, refResult(o, a, b), isDivOp(o) ? DIV_N : MUL_N);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    w = 0;
    while (expQ.size() != 0 && w < 100) begin
      w++;
      @(negedge clk);
    end
    check("queue_drained", 64'(expQ.size()), 64'd0);
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
